// File: rtl/tmds_serial_lanes.sv
// rtl/tmds_serial_lanes.sv - TMDS output stage: N data lanes plus clock lane, SDR/DDR serialiser
// Word-phase handshake, idle substitution, per-lane polarity swap and skew, registered p/n pairs.
module tmds_serial_lanes #(
  parameter int C_channels = 3,
  parameter int C_ddr = 0,
  parameter int C_word = 10,
  parameter logic [C_word-1:0] C_idle = 10'b1101010100,
  parameter int C_max_skew = 3,
  localparam int B = (C_ddr != 0) ? 2 : 1,
  localparam int S = $clog2(C_max_skew + 1),
  localparam int L = C_channels + 1
) (
  input  logic                      clk_shift,
  input  logic                      rst_n,
  input  logic [C_channels*C_word-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [C_channels:0]       invert,
  input  logic [L*S-1:0]            skew,
  input  logic                      clear_underflow,
  output logic                      underflow,
  output logic [L*B-1:0]            out_p,
  output logic [L*B-1:0]            out_n
);

  localparam int N = C_word / B;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(N - 1);
  localparam logic [C_word-1:0] CLK_PAT = {C_word{1'b1}} >> (C_word - C_word / 2);
  localparam logic [S-1:0] SKEW_MAX = S'(C_max_skew);

  logic [PW-1:0]     ph;
  logic [C_word-1:0] sh [L];

  assign in_ready = (ph == PH_LAST);

  // All lanes, including the clock lane, reload on the same edge so they stay bit-aligned.
  always_ff @(posedge clk_shift) begin
    if (!rst_n) begin
      ph        <= '0;
      underflow <= 1'b0;
      for (int i = 0; i < C_channels; i++) sh[i] <= C_idle;
      sh[C_channels] <= CLK_PAT;
    end else begin
      ph <= in_ready ? '0 : ph + 1'b1;
      if (in_ready && !in_valid)
        underflow <= 1'b1;
      else if (clear_underflow)
        underflow <= 1'b0;
      if (in_ready) begin
        for (int i = 0; i < C_channels; i++)
          sh[i] <= in_valid ? in_data[i*C_word +: C_word] : C_idle;
        sh[C_channels] <= CLK_PAT;
      end else begin
        for (int i = 0; i < L; i++) sh[i] <= sh[i] >> B;
      end
    end
  end

  for (genvar i = 0; i < L; i++) begin : g_lane
    logic [S-1:0] sk_raw;
    logic [S-1:0] sk;
    logic [B-1:0] dl [C_max_skew];
    logic [B-1:0] tap;
    logic [B-1:0] q;

    assign sk_raw = skew[i*S +: S];
    assign sk     = (sk_raw > SKEW_MAX) ? SKEW_MAX : sk_raw;

    always_ff @(posedge clk_shift) begin
      if (!rst_n) begin
        for (int j = 0; j < C_max_skew; j++) dl[j] <= '0;
      end else begin
        dl[0] <= sh[i][B-1:0];
        for (int j = 1; j < C_max_skew; j++) dl[j] <= dl[j-1];
      end
    end

    // Skew 0 taps the shift register directly; skew k taps k stages back.
    always_comb begin
      tap = sh[i][B-1:0];
      for (int j = 1; j <= C_max_skew; j++)
        if (sk == S'(j)) tap = dl[j-1];
    end

    always_ff @(posedge clk_shift) begin
      if (!rst_n)
        q <= '0;
      else
        q <= tap ^ {B{invert[i]}};
    end

    assign out_p[i*B +: B] = q;
    assign out_n[i*B +: B] = ~q;
  end

endmodule

// File: tb/tb_tmds_serial_lanes.sv
// tb/tb_tmds_serial_lanes.sv - self-checking bench for tmds_serial_lanes (SDR and DDR instances)
// A symbol-indexed reference model predicts every output each cycle; directed literals pin it.
module tb_tmds_serial_lanes;

  localparam logic [9:0] IDLE = 10'b1101010100;
  localparam logic [9:0] CLKP = 10'b0000011111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  invert = '0;
  logic [7:0]  skew = '0;
  logic        clr = 1'b0;
  logic [29:0] dat [2];
  logic        vld [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", nm, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int B = g + 1;
    localparam int N = 10 / B;
    localparam int W = 4 * B;

    logic         in_ready;
    logic         underflow;
    logic [W-1:0] out_p;
    logic [W-1:0] out_n;

    tmds_serial_lanes #(.C_ddr(g)) dut (
      .clk_shift(clk),
      .rst_n(rst_n),
      .in_data(dat[g]),
      .in_valid(vld[g]),
      .in_ready(in_ready),
      .invert(invert),
      .skew(skew),
      .clear_underflow(clr),
      .underflow(underflow),
      .out_p(out_p),
      .out_n(out_n)
    );

    // Model: each lane plays its current symbol slice-by-slice; line[j] is the slice from j cycles ago.
    logic [9:0]   m_sym [4];
    logic [B-1:0] m_line [4][4];
    logic [W-1:0] m_p;
    logic [W-1:0] m_n;
    int           m_ph;
    bit           m_uf;
    bit           m_known = 1'b0;

    always @(posedge clk) begin
      if (!rst_n) begin
        m_ph = 0;
        m_uf = 1'b0;
        m_p = '0;
        for (int l = 0; l < 4; l++) begin
          m_sym[l] = (l < 3) ? IDLE : CLKP;
          for (int j = 0; j < 4; j++) m_line[l][j] = '0;
        end
        m_known = 1'b1;
      end else begin
        for (int l = 0; l < 4; l++) begin
          m_line[l][0] = m_sym[l][m_ph*B +: B];
          m_p[l*B +: B] = m_line[l][int'(skew[l*2 +: 2])] ^ {B{invert[l]}};
        end
        if (m_ph == N - 1 && !vld[g]) m_uf = 1'b1;
        else if (clr) m_uf = 1'b0;
        if (m_ph == N - 1) begin
          for (int l = 0; l < 3; l++) m_sym[l] = vld[g] ? dat[g][l*10 +: 10] : IDLE;
          m_sym[3] = CLKP;
        end
        m_ph = (m_ph + 1) % N;
        for (int l = 0; l < 4; l++)
          for (int j = 3; j > 0; j--) m_line[l][j] = m_line[l][j-1];
      end
      m_n = ~m_p;
    end

    always @(negedge clk) begin
      if (m_known) begin
        check("out_p", g, out_p, m_p);
        check("out_n", g, out_n, m_n);
        check("in_ready", g, in_ready, m_ph == N - 1);
        check("underflow", g, underflow, m_uf);
      end
    end
  end

  bit         sdr_exp [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  bit         idle_exp [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
  logic [1:0] ddr_exp [5] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b10};
  logic [1:0] ddr_clk [5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
  bit         hist [64];

  task automatic do_reset;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] sym;
    bit mid_done;
    dat[0] = '0; dat[1] = '0;
    vld[0] = 1'b0; vld[1] = 1'b0;

    // Directed SDR lane0 / DDR lane1 symbols, clock lanes, reset state, ready period
    dat[0] = {10'h0, 10'h0, 10'b1111100000};
    dat[1] = {10'h0, 10'b1001110010, 10'h0};
    vld[0] = 1'b1; vld[1] = 1'b1;
    do_reset();
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("rst_out_p", 0, inst[0].out_p, 4'h0);
        check("rst_out_n", 0, inst[0].out_n, 4'hF);
        check("rst_uf", 0, inst[0].underflow, 1'b0);
        check("rst_out_n", 1, inst[1].out_n, 8'hFF);
      end
      check("ready_lit", 0, inst[0].in_ready, (c % 10) == 0);
      check("ready_lit", 1, inst[1].in_ready, (c % 5) == 0);
      if (c >= 12) begin
        check("sdr_lane0_lit", 0, inst[0].out_p[0], sdr_exp[c-12]);
        check("sdr_clk_lit", 0, inst[0].out_p[3], c <= 16);
      end
      if (c >= 7 && c <= 11) begin
        check("ddr_lane1_lit", 1, inst[1].out_p[3:2], ddr_exp[c-7]);
        check("ddr_clk_lit", 1, inst[1].out_p[7:6], ddr_clk[c-7]);
      end
      @(posedge clk);
      #1;
    end

    // Underflow: idle substitution, sticky flag, clear, clear colliding with set
    vld[0] = 1'b0; vld[1] = 1'b0;
    do_reset();
    for (int c = 1; c <= 22; c++) begin
      clr = (c == 12) || (c == 20);
      @(negedge clk);
      if (c == 10 || c == 11 || c == 12 || c == 13 || c == 21)
        check("uf_lit", 0, inst[0].underflow, (c != 10) && (c != 13));
      if (c >= 12 && c <= 21) begin
        check("idle_lit", 0, inst[0].out_p[0], idle_exp[c-12]);
        check("idle_lit2", 0, inst[0].out_p[2:1], {2{idle_exp[c-12]}});
      end
      @(posedge clk);
      #1;
    end
    clr = 1'b0;

    // Skew 3 with invert on lane2 against lane0
    skew = 8'h30;
    invert = 4'b0100;
    vld[0] = 1'b1; vld[1] = 1'b1;
    do_reset();
    for (int c = 1; c < 64; c++) begin
      sym = 10'($urandom);
      dat[0] = {sym, sym, sym};
      dat[1] = {sym, sym, sym};
      @(negedge clk);
      hist[c] = inst[0].out_p[0];
      if (c >= 5) check("skew3_inv", 0, inst[0].out_n[2], hist[c-3]);
      @(posedge clk);
      #1;
    end

    // Randomised rounds, some with a reset dropped in mid-symbol
    for (int r = 0; r < 6; r++) begin
      invert = 4'($urandom);
      skew = 8'($urandom);
      do_reset();
      mid_done = 1'b0;
      for (int c = 1; c <= 150; c++) begin
        if ((r % 2) == 1 && !mid_done && c >= 60 && inst[0].m_ph == 4) begin
          rst_n = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          @(negedge clk);
          check("mid_rst_p", 0, inst[0].out_p, 4'h0);
          check("mid_rst_n", 0, inst[0].out_n, 4'hF);
          check("mid_rst_uf", 0, inst[0].underflow, 1'b0);
          check("mid_rst_ready", 0, inst[0].in_ready, 1'b0);
          mid_done = 1'b1;
        end
        for (int g = 0; g < 2; g++) begin
          dat[g] = 30'($urandom);
          vld[g] = ($urandom_range(0, 3) != 0);
        end
        clr = ($urandom_range(0, 15) == 0);
        @(posedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
